// File: rtl/alu_issue_unit_if.sv
// Handshake and ALU-side signal bundle for alu_issue_unit.
// slave: the issue unit. master: the requester, the ALU and the result consumer.
interface alu_issue_unit_if #(
  parameter int TAG_W = 4
);
  // request channel
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [31:0]      req_a_i;
  logic [31:0]      req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  // combinational ALU
  logic [31:0]      alu_data1_o;
  logic [31:0]      alu_data2_o;
  logic [2:0]       alu_ctrl_o;
  logic [31:0]      alu_data_i;
  logic             alu_zero_i;
  // response channel
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic             rsp_zero_o;
  logic [TAG_W-1:0] rsp_tag_o;
  // status
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    input  alu_data_i, alu_zero_i, rsp_ready_i,
    output req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_tag_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    output alu_data_i, alu_zero_i, rsp_ready_i,
    input  req_ready_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_tag_o, busy_o
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Sequential front end for the shared combinational ALU.
// Stage 1 registers the operands into the ALU, stage 2 captures the ALU
// result into an in-order result FIFO drained over valid/ready.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_issue_unit_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      data;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  req_t             req_d, req_q;
  logic             inflight_q;
  rsp_t [DEPTH-1:0] fifo_mem;
  rsp_t             head;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    occ;
  logic             accept, push, pop, rsp_valid, req_ready;

  // Credits count the inflight op as well as queued entries, so the op
  // sitting in the ALU always has a FIFO slot waiting for it. This keeps
  // req_ready a pure function of registered state.
  assign occ       = count_q + CW'(inflight_q);
  assign req_ready = (occ < CW'(DEPTH));
  assign rsp_valid = (count_q != '0);

  assign accept = bus.req_valid_i & req_ready;
  assign push   = inflight_q;
  assign pop    = rsp_valid & bus.rsp_ready_i;

  assign req_d = '{op: bus.req_op_i, a: bus.req_a_i, b: bus.req_b_i, tag: bus.req_tag_i};

  // Operand/ctrl/tag registers: load on accept, otherwise hold so the ALU
  // inputs stay quiet while idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      req_q <= '0;
    else if (accept) req_q <= req_d;
  end

  // Inflight flag: the ALU output is valid for the op accepted last cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) inflight_q <= 1'b0;
    else        inflight_q <= accept;
  end

  // FIFO storage: no reset needed, entries are qualified by count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= '{data: bus.alu_data_i, zero: bus.alu_zero_i, tag: req_q.tag};
  end

  // Write/read pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Occupancy count: push and pop together leave it unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head = fifo_mem[rd_ptr_q];

  assign bus.req_ready_o = req_ready;
  assign bus.alu_data1_o = req_q.a;
  assign bus.alu_data2_o = req_q.b;
  assign bus.alu_ctrl_o  = req_q.op;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = head.data;
  assign bus.rsp_zero_o  = head.zero;
  assign bus.rsp_tag_o   = head.tag;
  assign bus.busy_o      = inflight_q | rsp_valid;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a behavioural ALU drives alu_data_i, and a
// scoreboard of accepted requests predicts every response, credit and busy.
module tb_alu_issue_unit;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0, n_bad = 0, n_rsp = 0, cyc = 0;
  bit   stop  = 1'b0;

  typedef struct {
    logic [31:0]      data;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];

  alu_issue_unit_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a + b;
      3'd2:    return a + b;
      3'd3:    return a * b;
      3'd4:    return $signed(a) >>> b[4:0];
      3'd5:    return a << b[4:0];
      3'd6:    return a ^ b;
      default: return a - b;
    endcase
  endfunction

  // the shared combinational ALU
  assign bus.alu_data_i = ref_alu(bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o);
  assign bus.alu_zero_i = (bus.alu_data_i == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard: every negedge, compare credits/busy/responses against the
  // queue of accepted-but-not-popped requests.
  initial begin : cmp
    bit               hold;
    logic [31:0]      hd;
    logic             hz;
    logic [TAG_W-1:0] ht;
    exp_t             e;
    logic [31:0]      r;
    hold = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        chk("req_ready", bus.req_ready_o, exp_q.size() < DEPTH);
        chk("busy", bus.busy_o, exp_q.size() != 0);
        if (hold) begin
          chk("hold_valid", bus.rsp_valid_o, 1);
          chk("hold_data", bus.rsp_data_o, hd);
          chk("hold_zero", bus.rsp_zero_o, hz);
          chk("hold_tag", bus.rsp_tag_o, ht);
        end
        if (bus.rsp_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("stale_rsp", bus.rsp_valid_o, 0);
          end else if (bus.rsp_ready_i) begin
            e = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data_o, e.data);
            chk("rsp_zero", bus.rsp_zero_o, e.zero);
            chk("rsp_tag", bus.rsp_tag_o, e.tag);
            n_rsp++;
            pop_cyc.push_back(cyc);
          end
        end
        hold = bus.rsp_valid_o && !bus.rsp_ready_i;
        hd = bus.rsp_data_o;
        hz = bus.rsp_zero_o;
        ht = bus.rsp_tag_o;
        if (bus.req_valid_i && bus.req_ready_o) begin
          r = ref_alu(bus.req_op_i, bus.req_a_i, bus.req_b_i);
          exp_q.push_back('{data: r, zero: (r == 32'd0), tag: bus.req_tag_i});
        end
      end
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    bus.req_valid_i = 1'b0;
    chk("accept", ok, 1);
  endtask

  // Wait for the head response and compare against literal values.
  task automatic expect_rsp(input string nm, input logic [31:0] d, input logic z,
                            input logic [TAG_W-1:0] t);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (bus.rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_seen"}, ok, 1);
    if (ok) begin
      chk({nm, "_data"}, bus.rsp_data_o, d);
      chk({nm, "_zero"}, bus.rsp_zero_o, z);
      chk({nm, "_tag"}, bus.rsp_tag_o, t);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, n0;
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 3'd0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_tag_i   = '0;
    bus.rsp_ready_i = 1'b1;

    // reset takes effect without a clock edge
    #1 rst_i = 1'b0;
    #2;
    chk("rst_data1", bus.alu_data1_o, 0);
    chk("rst_data2", bus.alu_data2_o, 0);
    chk("rst_ctrl", bus.alu_ctrl_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("rel_ready", bus.req_ready_o, 1);

    // add 5+7: response visible exactly two cycles after accept
    issue(3'd1, 32'd5, 32'd7, 4'd3);
    @(negedge clk_i);
    chk("lat_early", bus.rsp_valid_o, 0);
    @(negedge clk_i);
    chk("lat_valid", bus.rsp_valid_o, 1);
    chk("add_data", bus.rsp_data_o, 32'd12);
    chk("add_zero", bus.rsp_zero_o, 0);
    chk("add_tag", bus.rsp_tag_o, 3);
    @(posedge clk_i);
    #1;

    issue(3'd7, 32'd9, 32'd9, 4'd4);
    expect_rsp("sub", 32'd0, 1'b1, 4'd4);
    issue(3'd5, 32'd1, 32'd63, 4'd5);
    expect_rsp("sll", 32'h8000_0000, 1'b0, 4'd5);
    issue(3'd4, 32'h8000_0010, 32'd4, 4'd6);
    expect_rsp("srai", 32'hF800_0001, 1'b0, 4'd6);
    issue(3'd3, 32'h0001_0000, 32'h0001_0000, 4'd7);
    expect_rsp("mul", 32'd0, 1'b1, 4'd7);

    // backpressure: four fill the credits, the fifth waits
    bus.rsp_ready_i = 1'b0;
    n0 = n_rsp;
    for (int k = 0; k < 4; k++) issue(3'd1, 32'(k), 32'd100, 4'(k + 8));
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 3'd6;
    bus.req_a_i     = 32'hAAAA_0000;
    bus.req_b_i     = 32'h0000_5555;
    bus.req_tag_i   = 4'd12;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("bp_stall", bus.req_ready_o, 0);
    end
    @(posedge clk_i);
    #1 bus.rsp_ready_i = 1'b1;
    issue(3'd6, 32'hAAAA_0000, 32'h0000_5555, 4'd12);
    drain();
    chk("bp_count", n_rsp - n0, 5);

    // sustained traffic: one accept per cycle, consecutive responses
    pop_cyc.delete();
    n0 = n_rsp;
    c0 = cyc;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) issue(3'd3, 32'h0001_0000, 32'h0001_0000, 4'(k));
      else        issue(3'(k % 8), 32'(k * 37 + 1), 32'(k + 2), 4'(k));
    end
    chk("sustain_cycles", cyc - c0, 16);
    drain();
    chk("sustain_count", n_rsp - n0, 16);
    if (pop_cyc.size() >= 16) chk("sustain_b2b", pop_cyc[pop_cyc.size() - 1] - pop_cyc[pop_cyc.size() - 16], 15);
    else chk("sustain_pops", pop_cyc.size(), 16);

    // reset with one inflight and two queued
    bus.rsp_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) issue(3'd1, 32'(k), 32'd1, 4'(k));
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_data1", bus.alu_data1_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("no_stale", bus.rsp_valid_o, 0);
    end
    @(posedge clk_i);
    #1;
    issue(3'd6, 32'h0000_00FF, 32'h0000_000F, 4'd9);
    expect_rsp("xor", 32'h0000_00F0, 1'b0, 4'd9);

    // random ops, random gaps, random consumer stalls
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk_i);
            #1;
          end
          op = 3'($urandom_range(7));
          a  = $urandom;
          b  = ($urandom_range(3) == 0) ? a : $urandom;
          issue(op, a, b, 4'($urandom_range(15)));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk_i);
          #1 bus.rsp_ready_i = ($urandom_range(2) != 0);
        end
      end
    join
    bus.rsp_ready_i = 1'b1;
    drain();
    chk("final_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
